// File: rtl/sipo_framer.sv
// Serial-to-parallel deserialiser with run-time frame length, selectable bit order,
// valid/ready output holding register and overrun flagging for dropped frames.
module sipo_framer #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CNT_W      = $clog2(DATA_WIDTH + 1)
) (
  input  logic                  clk,
  input  logic                  arst_n,
  input  logic                  serial_in,
  input  logic                  bit_valid,
  input  logic                  msb_first,
  input  logic [CNT_W-1:0]      frame_len,
  input  logic                  flush,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  overrun,
  output logic [CNT_W-1:0]      bit_count
);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  cfg_msb_q, cfg_msb_d;
  logic [CNT_W-1:0]      cfg_len_q, cfg_len_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  ovr_q, ovr_d;

  logic [CNT_W-1:0]      eff_len;
  logic [CNT_W-1:0]      cur_len;
  logic                  cur_msb;
  logic [DATA_WIDTH-1:0] word_nx;
  logic                  complete;
  logic                  xfer;

  assign eff_len = ((frame_len == '0) || (frame_len > CNT_W'(DATA_WIDTH)))
                   ? CNT_W'(DATA_WIDTH) : frame_len;

  // The first bit of a frame must already obey the incoming config, so use
  // the live inputs in IDLE and the latched copies once shifting.
  assign cur_len = (state_q == IDLE) ? eff_len   : cfg_len_q;
  assign cur_msb = (state_q == IDLE) ? msb_first : cfg_msb_q;

  assign word_nx = cur_msb ? {shift_q[DATA_WIDTH-2:0], serial_in}
                           : (shift_q | (DATA_WIDTH'(serial_in) << cnt_q));

  assign complete = !flush && bit_valid && ((cnt_q + CNT_W'(1)) == cur_len);
  assign xfer     = valid_q && out_ready;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      cnt_q     <= '0;
      cfg_msb_q <= 1'b0;
      cfg_len_q <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      cnt_q     <= cnt_d;
      cfg_msb_q <= cfg_msb_d;
      cfg_len_q <= cfg_len_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ovr_q     <= ovr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    cnt_d     = cnt_q;
    cfg_msb_d = cfg_msb_q;
    cfg_len_d = cfg_len_q;
    data_d    = data_q;
    valid_d   = valid_q;
    ovr_d     = 1'b0;

    if (flush) begin
      state_d = IDLE;
      shift_d = '0;
      cnt_d   = '0;
    end else if (bit_valid) begin
      if (state_q == IDLE) begin
        cfg_msb_d = msb_first;
        cfg_len_d = eff_len;
      end
      if (complete) begin
        state_d = IDLE;
        shift_d = '0;
        cnt_d   = '0;
      end else begin
        state_d = SHIFT;
        shift_d = word_nx;
        cnt_d   = cnt_q + CNT_W'(1);
      end
    end

    if (complete) begin
      if (!valid_q || xfer) begin
        data_d  = word_nx;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (xfer) begin
      valid_d = 1'b0;
    end
  end

  assign out_data  = data_q;
  assign out_valid = valid_q;
  assign overrun   = ovr_q;
  assign bit_count = cnt_q;

endmodule

// File: tb/tb_sipo_framer.sv
// Self-checking bench for sipo_framer (DATA_WIDTH=8): directed scenarios plus a
// randomized run, all checked against a queue-based frame model.
module tb_sipo_framer;

  localparam int unsigned DW = 8;
  localparam int unsigned CW = 4;

  logic          clk = 1'b0;
  logic          arst_n;
  logic          serial_in;
  logic          bit_valid;
  logic          msb_first;
  logic [CW-1:0] frame_len;
  logic          flush;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          overrun;
  logic [CW-1:0] bit_count;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: bits of the current partial frame, latched config, output stage.
  bit       bq[$];
  int       m_len;
  bit       m_msb;
  bit [7:0] m_data;
  bit       m_valid;
  bit       m_ovr;

  sipo_framer #(.DATA_WIDTH(DW), .CNT_W(CW)) dut (
    .clk       (clk),
    .arst_n    (arst_n),
    .serial_in (serial_in),
    .bit_valid (bit_valid),
    .msb_first (msb_first),
    .frame_len (frame_len),
    .flush     (flush),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .overrun   (overrun),
    .bit_count (bit_count)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    bq.delete();
    m_len   = 8;
    m_msb   = 1'b0;
    m_data  = '0;
    m_valid = 1'b0;
    m_ovr   = 1'b0;
  endtask

  // Drive one cycle of inputs, advance the model, then sample 1 time unit after the edge.
  task automatic step(input logic bv, input logic b, input logic fl, input logic rdy);
    bit [7:0] w;
    bit       xfer;
    bit       comp;
    bit_valid = bv;
    serial_in = b;
    flush     = fl;
    out_ready = rdy;
    xfer = m_valid && rdy;
    comp = 1'b0;
    w    = '0;
    if (fl) begin
      bq.delete();
    end else if (bv) begin
      if (bq.size() == 0) begin
        m_len = (frame_len == 0 || frame_len > 8) ? 8 : int'(frame_len);
        m_msb = msb_first;
      end
      bq.push_back(b);
      if (bq.size() == m_len) begin
        for (int i = 0; i < m_len; i++)
          if (m_msb) w[m_len-1-i] = bq[i];
          else       w[i]         = bq[i];
        comp = 1'b1;
        bq.delete();
      end
    end
    m_ovr = 1'b0;
    if (comp) begin
      if (!m_valid || xfer) begin
        m_data  = w;
        m_valid = 1'b1;
      end else begin
        m_ovr = 1'b1;
      end
    end else if (xfer) begin
      m_valid = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [7:0] w, input int len, input logic rdy);
    for (int i = 0; i < len; i++)
      step(1'b1, msb_first ? w[len-1-i] : w[i], 1'b0, rdy);
  endtask

  task automatic test_reset();
    n_checks++;
    if (out_valid !== 1'b0 || overrun !== 1'b0 || out_data !== 8'h00 || bit_count !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_state: valid=%b ovr=%b data=%h cnt=%0d, required 0/0/00/0",
               out_valid, overrun, out_data, bit_count);
    end
  endtask

  task automatic test_msb_frame();
    logic [7:0] bits;
    bits = 8'b1100_0001;
    frame_len = 4'd8;
    msb_first = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step(1'b1, bits[7-i], 1'b0, 1'b1);
      n_checks++;
      if (bit_count !== 4'(bq.size()) || out_valid !== m_valid) begin
        n_fail++;
        $display("FAIL msb_progress bit %0d: cnt=%0d valid=%b, required %0d/%b",
                 i, bit_count, out_valid, bq.size(), m_valid);
      end
    end
    n_checks++;
    if (out_data !== 8'hC1 || out_valid !== 1'b1 || overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL msb_frame: data=%h valid=%b ovr=%b, required c1/1/0", out_data, out_valid, overrun);
    end
    step(1'b0, 1'b0, 1'b0, 1'b1);
    n_checks++;
    if (out_valid !== 1'b0 || out_data !== 8'hC1) begin
      n_fail++;
      $display("FAIL msb_one_cycle_valid: valid=%b data=%h, required 0/c1", out_valid, out_data);
    end
  endtask

  task automatic test_lsb_and_latch();
    logic [7:0] bits;
    bits = 8'b1100_0001;
    msb_first = 1'b0;
    for (int i = 0; i < 8; i++) step(1'b1, bits[7-i], 1'b0, 1'b1);
    n_checks++;
    if (out_data !== 8'h83 || out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL lsb_frame: data=%h valid=%b, required 83/1", out_data, out_valid);
    end
    for (int i = 0; i < 8; i++) begin
      if (i == 2) msb_first = 1'b1;
      step(1'b1, bits[7-i], 1'b0, 1'b1);
    end
    n_checks++;
    if (out_data !== 8'h83 || out_data !== m_data) begin
      n_fail++;
      $display("FAIL config_latched: data=%h, required 83", out_data);
    end
    step(1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_short_len();
    logic [4:0] bits;
    logic [CW-1:0] exp_cnt[5];
    bits = 5'b10110;
    exp_cnt = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd0};
    frame_len = 4'd5;
    msb_first = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step(1'b1, bits[4-i], 1'b0, 1'b1);
      n_checks++;
      if (bit_count !== exp_cnt[i]) begin
        n_fail++;
        $display("FAIL len5_count bit %0d: cnt=%0d, required %0d", i, bit_count, exp_cnt[i]);
      end
    end
    n_checks++;
    if (out_data !== 8'h16 || out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL len5_frame: data=%h valid=%b, required 16/1", out_data, out_valid);
    end
    frame_len = 4'd0;
    send_word(8'hB7, 8, 1'b1);
    n_checks++;
    if (out_data !== 8'hB7 || out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL len0_as_8: data=%h valid=%b, required b7/1", out_data, out_valid);
    end
    frame_len = 4'd12;
    send_word(8'h4E, 8, 1'b1);
    n_checks++;
    if (out_data !== 8'h4E || bit_count !== 4'd0) begin
      n_fail++;
      $display("FAIL len12_as_8: data=%h cnt=%0d, required 4e/0", out_data, bit_count);
    end
    frame_len = 4'd1;
    step(1'b1, 1'b1, 1'b0, 1'b1);
    n_checks++;
    if (out_data !== 8'h01 || bit_count !== 4'd0 || out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL len1: data=%h cnt=%0d valid=%b, required 01/0/1", out_data, bit_count, out_valid);
    end
    step(1'b0, 1'b0, 1'b0, 1'b1);
    frame_len = 4'd8;
  endtask

  task automatic test_back_to_back();
    msb_first = 1'b1;
    frame_len = 4'd8;
    send_word(8'hA5, 8, 1'b0);
    send_word(8'h3C, 8, 1'b0);
    n_checks++;
    if (out_data !== 8'hA5 || overrun !== 1'b1 || out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_overrun: data=%h ovr=%b valid=%b, required a5/1/1", out_data, overrun, out_valid);
    end
    step(1'b0, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (overrun !== 1'b0 || out_data !== 8'hA5 || out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_overrun_pulse: ovr=%b data=%h valid=%b, required 0/a5/1", overrun, out_data, out_valid);
    end
    step(1'b0, 1'b0, 1'b0, 1'b1);
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_release: valid=%b, required 0", out_valid);
    end
    send_word(8'hA5, 8, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b1, 1'(8'h3C >> (7 - i)), 1'b0, (i == 7));
    n_checks++;
    if (out_data !== 8'h3C || out_valid !== 1'b1 || overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_same_cycle: data=%h valid=%b ovr=%b, required 3c/1/0", out_data, out_valid, overrun);
    end
    step(1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_flush();
    msb_first = 1'b1;
    frame_len = 4'd8;
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b1);
    n_checks++;
    if (bit_count !== 4'd0 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_clear: cnt=%0d valid=%b, required 0/0", bit_count, out_valid);
    end
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'(8'h5A >> (7 - i)), 1'b0, 1'b1);
      n_checks++;
      if (out_valid !== (i == 7)) begin
        n_fail++;
        $display("FAIL flush_no_spurious bit %0d: valid=%b, required %b", i, out_valid, (i == 7));
      end
    end
    n_checks++;
    if (out_data !== 8'h5A) begin
      n_fail++;
      $display("FAIL flush_frame: data=%h, required 5a", out_data);
    end
    step(1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_reset_mid();
    msb_first = 1'b1;
    frame_len = 4'd8;
    send_word(8'hFF, 8, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
    #2 arst_n = 1'b0;
    #1;
    model_reset();
    n_checks++;
    if (out_valid !== 1'b0 || out_data !== 8'h00 || bit_count !== 4'd0) begin
      n_fail++;
      $display("FAIL async_reset: valid=%b data=%h cnt=%0d, required 0/00/0", out_valid, out_data, bit_count);
    end
    bit_valid = 1'b0;
    @(posedge clk);
    #1 arst_n = 1'b1;
    send_word(8'h81, 8, 1'b1);
    n_checks++;
    if (out_data !== 8'h81 || out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL post_reset_frame: data=%h valid=%b, required 81/1", out_data, out_valid);
    end
    step(1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      msb_first = 1'($urandom);
      if ($urandom_range(0, 3) == 0) frame_len = 4'($urandom_range(0, 15));
      step(($urandom_range(0, 3) != 0), 1'($urandom), ($urandom_range(0, 19) == 0),
           ($urandom_range(0, 2) != 0));
      n_checks++;
      if (out_data !== m_data || out_valid !== m_valid || overrun !== m_ovr ||
          bit_count !== 4'(bq.size())) begin
        n_fail++;
        $display("FAIL random cycle %0d: data=%h valid=%b ovr=%b cnt=%0d, required %h/%b/%b/%0d",
                 c, out_data, out_valid, overrun, bit_count, m_data, m_valid, m_ovr, bq.size());
      end
    end
  endtask

  initial begin
    arst_n    = 1'b0;
    serial_in = 1'b0;
    bit_valid = 1'b0;
    msb_first = 1'b1;
    frame_len = 4'd8;
    flush     = 1'b0;
    out_ready = 1'b0;
    model_reset();
    #12;
    test_reset();
    arst_n = 1'b1;
    step(1'b0, 1'b0, 1'b0, 1'b0);
    test_reset();
    test_msb_frame();
    test_lsb_and_latch();
    test_short_len();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
